// File: rtl/id_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_unit_pkg
// Description : Shared stall-cause codes and register constants for the ID
//               stage hazard / forwarding unit.
// Revision    : 1.0 - initial release
// ============================================================================
package id_hazard_unit_pkg;

    // Stall cause reported alongside the stall line
    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_LOAD   = 2'd1,
        CAUSE_SB     = 2'd2,
        CAUSE_STRUCT = 2'd3
    } stall_cause_e;

    // Architectural zero register: never forwarded, never a dependency
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : id_hazard_unit_pkg
`default_nettype wire

// File: rtl/id_hazard_unit_fwd_select.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_unit_fwd_select
// Description : Priority operand select for one source register. The lowest
//               matching forwarding stage (youngest) wins; register 0 always
//               reads as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_unit_fwd_select
    import id_hazard_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic [4:0]              addr,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]      fwd_wena,
    input  logic [5*NUM_FWD-1:0]    fwd_waddr,
    input  logic [NUM_FWD-1:0]      fwd_ready,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    output logic [XLEN-1:0]         data,
    output logic                    hit,
    output logic                    not_ready
);

    // Walk oldest to youngest so the youngest match overwrites; only the
    // selected stage's readiness matters, older matches are shadowed.
    always_comb begin
        data      = rf_data;
        hit       = 1'b0;
        not_ready = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (fwd_wena[i] && (fwd_waddr[5*i +: 5] == addr)) begin
                data      = fwd_data[XLEN*i +: XLEN];
                hit       = 1'b1;
                not_ready = !fwd_ready[i];
            end
        end
        if (addr == REG_ZERO) begin
            data      = '0;
            hit       = 1'b0;
            not_ready = 1'b0;
        end
    end

endmodule : id_hazard_unit_fwd_select
`default_nettype wire

// File: rtl/id_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : id_hazard_unit
// Description : ID-stage operand forwarding over NUM_FWD stages, load-use
//               detection, single-entry scoreboard for a long-latency unit,
//               structural stall and saturating hazard-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_hazard_unit
    import id_hazard_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int MC_LAT  = 32,
    parameter int CNT_W   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stop,
    input  logic                    id_valid,
    input  logic [4:0]              id_rs,
    input  logic [4:0]              id_rt,
    input  logic                    id_rs_rena,
    input  logic                    id_rt_rena,
    input  logic [XLEN-1:0]         rf_rs_data,
    input  logic [XLEN-1:0]         rf_rt_data,
    input  logic [NUM_FWD-1:0]      fwd_wena,
    input  logic [5*NUM_FWD-1:0]    fwd_waddr,
    input  logic [NUM_FWD-1:0]      fwd_ready,
    input  logic [XLEN*NUM_FWD-1:0] fwd_data,
    input  logic                    mc_issue,
    input  logic [4:0]              mc_waddr,
    input  logic                    mc_done,
    output logic [XLEN-1:0]         rs_data,
    output logic [XLEN-1:0]         rt_data,
    output logic                    stall,
    output logic [1:0]              stall_cause,
    output logic                    mc_busy,
    output logic [31:0]             stall_cnt
);

    // Counter reload: the issue cycle's edge already counts as one cycle
    localparam logic [CNT_W-1:0] MC_LAT_M1 = CNT_W'(MC_LAT - 1);

    logic             rs_hit, rs_not_ready;
    logic             rt_hit, rt_not_ready;
    logic [4:0]       mc_dest;
    logic [CNT_W-1:0] mc_cnt;
    logic             load_hz, sb_hz, struct_hz, hazard, issue_ok;
    stall_cause_e     cause;

    id_hazard_unit_fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_select_rs (
        .addr      (id_rs),
        .rf_data   (rf_rs_data),
        .fwd_wena  (fwd_wena),
        .fwd_waddr (fwd_waddr),
        .fwd_ready (fwd_ready),
        .fwd_data  (fwd_data),
        .data      (rs_data),
        .hit       (rs_hit),
        .not_ready (rs_not_ready)
    );

    id_hazard_unit_fwd_select #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_select_rt (
        .addr      (id_rt),
        .rf_data   (rf_rt_data),
        .fwd_wena  (fwd_wena),
        .fwd_waddr (fwd_waddr),
        .fwd_ready (fwd_ready),
        .fwd_data  (fwd_data),
        .data      (rt_data),
        .hit       (rt_hit),
        .not_ready (rt_not_ready)
    );

    // Hazard classification with fixed priority load-use > scoreboard > structural
    always_comb begin
        load_hz   = id_valid & ((id_rs_rena & rs_hit & rs_not_ready) |
                                (id_rt_rena & rt_hit & rt_not_ready));
        sb_hz     = id_valid & mc_busy & (mc_dest != REG_ZERO) &
                    ((id_rs_rena & (id_rs == mc_dest)) |
                     (id_rt_rena & (id_rt == mc_dest)));
        struct_hz = id_valid & mc_issue & mc_busy;
        hazard    = load_hz | sb_hz | struct_hz;
        if (load_hz)        cause = CAUSE_LOAD;
        else if (sb_hz)     cause = CAUSE_SB;
        else if (struct_hz) cause = CAUSE_STRUCT;
        else                cause = CAUSE_NONE;
        stall       = stop | hazard;
        stall_cause = cause;
        issue_ok    = id_valid & mc_issue & ~stall;
    end

    // Scoreboard entry and latency counter; counting ignores stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_busy <= 1'b0;
            mc_dest <= REG_ZERO;
            mc_cnt  <= '0;
        end else if (issue_ok) begin
            mc_busy <= 1'b1;
            mc_dest <= mc_waddr;
            mc_cnt  <= MC_LAT_M1;
        end else if (mc_busy) begin
            if ((mc_cnt == '0) || mc_done) begin
                mc_busy <= 1'b0;
            end else begin
                mc_cnt <= mc_cnt - 1'b1;
            end
        end
    end

    // Saturating count of hazard cycles; external stop alone is not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (hazard && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule : id_hazard_unit
`default_nettype wire

// File: tb/tb_id_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_hazard_unit
// Description : Directed self-checking bench for id_hazard_unit with
//               MC_LAT=4, covering forwarding, load-use, scoreboard,
//               structural stall, external stop and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_hazard_unit;
    import id_hazard_unit_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUM_FWD = 2;
    localparam int MC_LAT  = 4;
    localparam int CNT_W   = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    stop;
    logic                    id_valid;
    logic [4:0]              id_rs, id_rt;
    logic                    id_rs_rena, id_rt_rena;
    logic [XLEN-1:0]         rf_rs_data, rf_rt_data;
    logic [NUM_FWD-1:0]      fwd_wena;
    logic [5*NUM_FWD-1:0]    fwd_waddr;
    logic [NUM_FWD-1:0]      fwd_ready;
    logic [XLEN*NUM_FWD-1:0] fwd_data;
    logic                    mc_issue;
    logic [4:0]              mc_waddr;
    logic                    mc_done;
    logic [XLEN-1:0]         rs_data, rt_data;
    logic                    stall;
    logic [1:0]              stall_cause;
    logic                    mc_busy;
    logic [31:0]             stall_cnt;

    int errors = 0;
    int checks = 0;
    int n;

    id_hazard_unit #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD),
        .MC_LAT  (MC_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stop        (stop),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_rs_rena  (id_rs_rena),
        .id_rt_rena  (id_rt_rena),
        .rf_rs_data  (rf_rs_data),
        .rf_rt_data  (rf_rt_data),
        .fwd_wena    (fwd_wena),
        .fwd_waddr   (fwd_waddr),
        .fwd_ready   (fwd_ready),
        .fwd_data    (fwd_data),
        .mc_issue    (mc_issue),
        .mc_waddr    (mc_waddr),
        .mc_done     (mc_done),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .stall       (stall),
        .stall_cause (stall_cause),
        .mc_busy     (mc_busy),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stop = 1'b0; id_valid = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rs_rena = 1'b0; id_rt_rena = 1'b0;
        rf_rs_data = 32'h0000_1234; rf_rt_data = 32'h0000_BEEF;
        fwd_wena = '0; fwd_waddr = '0; fwd_ready = '1; fwd_data = '0;
        mc_issue = 1'b0; mc_waddr = 5'd0; mc_done = 1'b0;
        tick(); tick();
        check("rst_busy", {31'd0, mc_busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_cause", {30'd0, stall_cause}, CAUSE_NONE);
        check("rst_cnt", stall_cnt, 32'd0);
        rst = 1'b0;
        tick();

        // Forward priority: both stages write r5, youngest wins
        id_valid = 1'b1; id_rs = 5'd5; id_rs_rena = 1'b1; id_rt = 5'd3; id_rt_rena = 1'b1;
        fwd_wena = 2'b11; fwd_waddr = {5'd5, 5'd5};
        fwd_data = {32'h0000_5555, 32'h0000_AAAA}; fwd_ready = 2'b11;
        #1;
        check("fwd_prio", rs_data, 32'h0000_AAAA);
        check("fwd_rf_rt", rt_data, 32'h0000_BEEF);
        check("fwd_nostall", {31'd0, stall}, 32'd0);
        fwd_waddr = {5'd5, 5'd7};
        #1;
        check("fwd_stage1", rs_data, 32'h0000_5555);
        fwd_waddr = {5'd0, 5'd0}; id_rs = 5'd0;
        #1;
        check("fwd_r0", rs_data, 32'd0);
        fwd_wena = 2'b00; id_rs = 5'd5;
        #1;
        check("fwd_none", rs_data, 32'h0000_1234);

        // Load-use on rt via stage 0, older ready match on stage 1 is shadowed
        id_rs = 5'd1; id_rt = 5'd8;
        fwd_wena = 2'b11; fwd_waddr = {5'd8, 5'd8}; fwd_ready = 2'b10;
        fwd_data = {32'h0000_0077, 32'h0000_0066};
        #1;
        check("lu_stall", {31'd0, stall}, 32'd1);
        check("lu_cause", {30'd0, stall_cause}, CAUSE_LOAD);
        id_rt_rena = 1'b0;
        #1;
        check("lu_rena_gate", {31'd0, stall}, 32'd0);
        id_rt_rena = 1'b1; id_valid = 1'b0;
        #1;
        check("lu_valid_gate", {31'd0, stall}, 32'd0);
        id_valid = 1'b1;
        tick();
        fwd_wena = 2'b10; fwd_waddr = {5'd8, 5'd0}; fwd_ready = 2'b11;
        fwd_data = {32'h0000_0088, 32'h0};
        #1;
        check("lu_fwd_data", rt_data, 32'h0000_0088);
        check("lu_release", {31'd0, stall}, 32'd0);
        check("lu_cnt", stall_cnt, 32'd1);
        fwd_wena = 2'b00;

        // Scoreboard: full latency
        id_rs = 5'd1; id_rt_rena = 1'b0; mc_issue = 1'b1; mc_waddr = 5'd9;
        #1;
        check("sb_issue_ok", {31'd0, stall}, 32'd0);
        tick();
        mc_issue = 1'b0; id_rs = 5'd9;
        check("sb_busy", {31'd0, mc_busy}, 32'd1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (stall !== 1'b1) break;
            check("sb_cause", {30'd0, stall_cause}, CAUSE_SB);
            n++;
            tick();
        end
        check("sb_cycles", n, 32'd4);
        check("sb_cnt", stall_cnt, 32'd5);

        // Scoreboard: early completion in second busy cycle
        id_rs = 5'd1; mc_issue = 1'b1;
        tick();
        mc_issue = 1'b0; id_rs = 5'd9;
        #1;
        check("sbd_stall1", {31'd0, stall}, 32'd1);
        tick();
        mc_done = 1'b1;
        #1;
        check("sbd_stall2", {31'd0, stall}, 32'd1);
        tick();
        mc_done = 1'b0;
        #1;
        check("sbd_release", {31'd0, stall}, 32'd0);
        check("sbd_busy", {31'd0, mc_busy}, 32'd0);
        check("sbd_cnt", stall_cnt, 32'd7);

        // Structural: second issue while busy waits for release
        id_rs = 5'd1; mc_issue = 1'b1; mc_waddr = 5'd10;
        tick();
        mc_waddr = 5'd11;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (stall !== 1'b1) break;
            check("st_cause", {30'd0, stall_cause}, CAUSE_STRUCT);
            n++;
            tick();
        end
        check("st_cycles", n, 32'd4);
        tick();
        check("st_accept", {31'd0, mc_busy}, 32'd1);
        check("st_cnt", stall_cnt, 32'd11);

        // External stop: stall without cause, counter keeps running
        mc_issue = 1'b0; stop = 1'b1;
        #1;
        check("stop_stall", {31'd0, stall}, 32'd1);
        check("stop_cause", {30'd0, stall_cause}, CAUSE_NONE);
        tick(); tick(); tick();
        check("stop_busy3", {31'd0, mc_busy}, 32'd1);
        tick();
        check("stop_busy4", {31'd0, mc_busy}, 32'd0);
        check("stop_cnt", stall_cnt, 32'd11);
        stop = 1'b0;

        // Issue to r0 sets busy but never blocks an r0 reader
        mc_issue = 1'b1; mc_waddr = 5'd0; id_rs = 5'd0;
        tick();
        mc_issue = 1'b0;
        #1;
        check("r0_busy", {31'd0, mc_busy}, 32'd1);
        check("r0_nostall", {31'd0, stall}, 32'd0);

        // Async reset mid-operation
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, mc_busy}, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_cnt", stall_cnt, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_id_hazard_unit
`default_nettype wire
